rf_multiport_sb: RTL and testbench
==================================

Name: rf_multiport_sb

Overview:
- Parametrised successor to the core's integer register file.
- Provides N combinational read ports and M clocked write ports, with optional write-to-read bypass and a per-register pending-write scoreboard for pipeline hazard detection.
- Sits in the decode/writeback boundary of the pipelined core. Decode reads operands and marks destination registers pending; writeback retires them.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; must be a power of 2, at least 2.
- IDXW, $clog2(NREG), register index width.
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- ra  in  NRD*IDXW  read addresses; port k uses bits [k*IDXW +: IDXW].
- rd  out  NRD*XLEN  read data, port k.
- rd_pend  out  NRD  port k's register has an outstanding producer.
- we  in  NWR  write enables.
- wa  in  NWR*IDXW  write addresses.
- wd  in  NWR*XLEN  write data.
- alloc_v  in  1  decode issues an instruction with a destination register.
- alloc_idx  in  IDXW  destination register to mark pending.
- flush  in  1  synchronous clear of all pending bits (branch redirect).
- pend_cnt  out  IDXW+1  number of registers currently pending.

Behaviour:
- Reset (rstn=0, asynchronous): all registers cleared to 0, all pending bits 0, pend_cnt=0. rd outputs read 0. Reset mid-stream discards in-flight writes; no writes occur while rstn=0.
- Register 0: hardwired. Writes to index 0 ignored; reads of index 0 return 0; alloc to index 0 ignored; rd_pend for index 0 always 0.
- Write: on posedge, for each port j with we[j]=1 and wa[j]!=0, rf[wa[j]] <= wd[j]. Latency: value visible in storage next cycle.
- Same-address multi-write: the highest-numbered port wins. The bypass path applies the same priority.
- Read: fully combinational; zero latency.
- Bypass (BYPASS=1): if any we[j]=1 and wa[j]=ra[k]!=0, rd[k]=wd[j] (highest j), else rf[ra[k]].
- No bypass (BYPASS=0): rd[k]=rf[ra[k]] (old value until the edge).
- Scoreboard set: pend[alloc_idx] set to 1 at posedge when alloc_v=1 and alloc_idx!=0.
- Scoreboard clear: pend[wa[j]] cleared at posedge for every enabled write port.
- Set and clear of the same index in one cycle: set wins (new producer supersedes).
- Allocating an already-pending register: it stays pending. There is no counting per register.
- flush=1: all pend bits cleared at posedge. flush takes priority over alloc_v in the same cycle. Register data is unaffected; writes in that cycle still commit.
- rd_pend[k]:
  - BYPASS=1: pend[ra[k]] AND NOT (a same-cycle write to ra[k]).
  - BYPASS=0: raw pend[ra[k]].
- pend_cnt: registered popcount of pend, equal to the popcount of the current pend state. Range 0..NREG-1.
- No $display/side-effect output is produced by this block.

Decomposition:
- Shared defines header: XLEN, RFIDX_WIDTH, RFREG_NUM defaults.
- Sub-module rf_scoreboard: pend vector, set/clear/flush priority, pend_cnt.
- Top module: storage, write priority, and the read/bypass muxes.

Test Plan:
- Reset then read: rstn low 3 cycles, release; ra={5,0} -> rd={0,0}, rd_pend=0, pend_cnt=0.
- Basic write/read: we=01, wa0=3, wd0=0xDEADBEEF; next cycle ra0=3 -> rd0=0xDEADBEEF. A write to x0 of 0x1234 leaves rd(x0)=0.
- Dual write collision: wa0=wa1=7, wd0=0x11, wd1=0x22 -> same-cycle bypass read of x7 = 0x22; after the edge rf[7]=0x22. With BYPASS=0 the same-cycle read returns the old value 0.
- Scoreboard lifecycle:
  - alloc x9 -> rd_pend(ra=9)=1, pend_cnt=1.
  - Write x9=0x55 -> same-cycle rd_pend=0 and rd=0x55; next cycle pend_cnt=0.
  - alloc x9 and write x9 in one cycle -> x9 stays pending.
- Flush: alloc x1, x2, x4 over 3 cycles (pend_cnt=3); flush together with alloc x6 -> pend_cnt=0 and x6 not pending.
- Async reset mid-operation: assert rstn low between edges while we=1, wa=10 -> rf[10]=0 immediately; the write does not commit on the following edge while in reset.

Source files
------------

// File: rtl/rf_multiport_sb_pkg.sv
// Shared defaults for the integer register file family.
package rf_multiport_sb_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int RFREG_NUM_DEF = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: set on alloc, clear on write, flush clears all.
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int IDXW = $clog2(NREG),
    parameter int NWR  = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                alloc_v,
    input  logic [IDXW-1:0]     alloc_idx,
    input  logic [NWR-1:0]      clr_v,
    input  logic [NWR*IDXW-1:0] clr_idx,
    input  logic                flush,
    output logic [NREG-1:0]     pend,
    output logic [IDXW:0]       pend_cnt
);

    logic [NREG-1:0] pend_d, pend_q;
    logic [IDXW:0]   pend_cnt_d, pend_cnt_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (clr_v[j]) pend_d[clr_idx[j*IDXW +: IDXW]] = 1'b0;
            end
            // Applied after the clears so a new producer supersedes a retiring one.
            if (alloc_v && alloc_idx != '0) pend_d[alloc_idx] = 1'b1;
        end
        pend_d[0] = 1'b0;

        pend_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_d = pend_cnt_d + (IDXW+1)'(pend_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend     = pend_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-port integer register file with optional write bypass and pending-write scoreboard.
module rf_multiport_sb
    import rf_multiport_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = RFREG_NUM_DEF,
    parameter int IDXW   = $clog2(NREG),
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*IDXW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_pend,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*IDXW-1:0] wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                alloc_v,
    input  logic [IDXW-1:0]     alloc_idx,
    input  logic                flush,
    output logic [IDXW:0]       pend_cnt
);

    logic [XLEN-1:0] rf_d [NREG];
    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] pend;

    // Ascending port order lets the highest-numbered port win a same-address collision.
    always_comb begin
        rf_d = rf_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j]) rf_d[wa[j*IDXW +: IDXW]] = wd[j*XLEN +: XLEN];
        end
        rf_d[0] = '0;
    end

    // NOTE: the storage array is reset because a reset must clear architectural state to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IDXW-1:0] idx;
        logic [XLEN-1:0] val;
        logic            hit;

        assign idx = ra[k*IDXW +: IDXW];

        always_comb begin
            val = rf_q[idx];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && wa[j*IDXW +: IDXW] == idx) begin
                        val = wd[j*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
            end
            if (idx == '0 || !rstn) begin
                val = '0;
                hit = 1'b0;
            end
        end

        assign rd[k*XLEN +: XLEN] = val;
        assign rd_pend[k]         = pend[idx] & ~hit;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .IDXW (IDXW),
        .NWR  (NWR)
    ) u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .alloc_v   (alloc_v),
        .alloc_idx (alloc_idx),
        .clr_v     (we),
        .clr_idx   (wa),
        .flush     (flush),
        .pend      (pend),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed bench for rf_multiport_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_rf_multiport_sb;

    localparam int XLEN = 32;
    localparam int IDXW = 5;

    typedef enum int {
        OBS_RD0, OBS_RD1, OBS_PEND, OBS_CNT, OBS_NB_RD0, OBS_NB_RD1, OBS_NB_PEND
    } obs_e;

    typedef struct {
        string tag;
        obs_e  sel;
        logic [31:0] val;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [2*IDXW-1:0] ra;
    logic [2*XLEN-1:0] rd, nb_rd;
    logic [1:0]        rd_pend, nb_rd_pend;
    logic [1:0]        we;
    logic [2*IDXW-1:0] wa;
    logic [2*XLEN-1:0] wd;
    logic              alloc_v;
    logic [IDXW-1:0]   alloc_idx;
    logic              flush;
    logic [IDXW:0]     pend_cnt, nb_pend_cnt;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    rf_multiport_sb #(.BYPASS(1)) u_dut (
        .clk(clk), .rstn(rstn), .ra(ra), .rd(rd), .rd_pend(rd_pend),
        .we(we), .wa(wa), .wd(wd), .alloc_v(alloc_v), .alloc_idx(alloc_idx),
        .flush(flush), .pend_cnt(pend_cnt)
    );

    rf_multiport_sb #(.BYPASS(0)) u_nb (
        .clk(clk), .rstn(rstn), .ra(ra), .rd(nb_rd), .rd_pend(nb_rd_pend),
        .we(we), .wa(wa), .wd(wd), .alloc_v(alloc_v), .alloc_idx(alloc_idx),
        .flush(flush), .pend_cnt(nb_pend_cnt)
    );

    function automatic logic [31:0] observe(obs_e sel);
        case (sel)
            OBS_RD0:     return rd[31:0];
            OBS_RD1:     return rd[63:32];
            OBS_PEND:    return {30'd0, rd_pend};
            OBS_CNT:     return {26'd0, pend_cnt};
            OBS_NB_RD0:  return nb_rd[31:0];
            OBS_NB_RD1:  return nb_rd[63:32];
            default:     return {30'd0, nb_rd_pend};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic expect_v(input string tag, input obs_e sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Settle combinational paths, then compare everything queued so far.
    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 2'b00; wa = '0; wd = '0; alloc_v = 1'b0; alloc_idx = '0; flush = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ra = '0;
        idle();
        repeat (3) step();
        rstn = 1'b1;

        // Reset state
        ra = {5'd0, 5'd5};
        expect_v("rst_rd0", OBS_RD0, 32'h0);
        expect_v("rst_rd1", OBS_RD1, 32'h0);
        expect_v("rst_pend", OBS_PEND, 32'h0);
        expect_v("rst_cnt", OBS_CNT, 32'h0);
        drain();

        // Basic write on port 0, write to x0 on port 1
        we = 2'b11; wa = {5'd0, 5'd3}; wd = {32'h0000_1234, 32'hDEAD_BEEF};
        ra = {5'd0, 5'd3};
        expect_v("wr_byp_rd0", OBS_RD0, 32'hDEAD_BEEF);
        expect_v("wr_nb_old_rd0", OBS_NB_RD0, 32'h0);
        expect_v("wr_x0_byp", OBS_RD1, 32'h0);
        drain();
        step();
        idle();
        expect_v("wr_rd0", OBS_RD0, 32'hDEAD_BEEF);
        expect_v("wr_nb_rd0", OBS_NB_RD0, 32'hDEAD_BEEF);
        expect_v("wr_x0_rd1", OBS_RD1, 32'h0);
        expect_v("wr_x0_nb_rd1", OBS_NB_RD1, 32'h0);
        drain();

        // Dual-write collision on x7
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        ra = {5'd3, 5'd7};
        expect_v("col_byp", OBS_RD0, 32'h22);
        expect_v("col_nb_old", OBS_NB_RD0, 32'h0);
        drain();
        step();
        idle();
        expect_v("col_rf", OBS_RD0, 32'h22);
        expect_v("col_nb_rf", OBS_NB_RD0, 32'h22);
        drain();

        // Scoreboard lifecycle on x9
        alloc_v = 1'b1; alloc_idx = 5'd9;
        step();
        idle();
        ra = {5'd0, 5'd9};
        expect_v("sb_pend", OBS_PEND, 32'h1);
        expect_v("sb_nb_pend", OBS_NB_PEND, 32'h1);
        expect_v("sb_cnt1", OBS_CNT, 32'd1);
        drain();
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h55};
        expect_v("sb_wr_pend", OBS_PEND, 32'h0);
        expect_v("sb_wr_rd", OBS_RD0, 32'h55);
        expect_v("sb_nb_wr_pend", OBS_NB_PEND, 32'h1);
        drain();
        step();
        idle();
        expect_v("sb_cnt0", OBS_CNT, 32'd0);
        expect_v("sb_rd_after", OBS_RD0, 32'h55);
        drain();
        alloc_v = 1'b1; alloc_idx = 5'd9;
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h66};
        step();
        idle();
        expect_v("sb_setwins_pend", OBS_PEND, 32'h1);
        expect_v("sb_setwins_cnt", OBS_CNT, 32'd1);
        expect_v("sb_setwins_rd", OBS_RD0, 32'h66);
        drain();
        we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h77, 32'h0};
        step();
        idle();
        expect_v("sb_retire_cnt", OBS_CNT, 32'd0);
        drain();

        // Allocation of x0 is ignored
        alloc_v = 1'b1; alloc_idx = 5'd0;
        step();
        idle();
        ra = {5'd0, 5'd0};
        expect_v("x0_alloc_cnt", OBS_CNT, 32'd0);
        expect_v("x0_alloc_pend", OBS_PEND, 32'h0);
        drain();

        // Flush beats a same-cycle alloc; writes in the flush cycle still commit
        for (int i = 0; i < 3; i++) begin
            alloc_v = 1'b1; alloc_idx = 5'(1 << i);
            step();
        end
        idle();
        expect_v("fl_cnt3", OBS_CNT, 32'd3);
        drain();
        flush = 1'b1; alloc_v = 1'b1; alloc_idx = 5'd6;
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hAB};
        step();
        idle();
        ra = {5'd5, 5'd6};
        expect_v("fl_cnt0", OBS_CNT, 32'd0);
        expect_v("fl_x6_pend", OBS_PEND, 32'h0);
        expect_v("fl_wr_commit", OBS_RD1, 32'hAB);
        drain();

        // Asynchronous reset between edges
        we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'h0, 32'h1010};
        step();
        wa = {5'd0, 5'd10}; wd = {32'h0, 32'hCAFE};
        ra = {5'd0, 5'd10};
        expect_v("ar_pre_byp", OBS_RD0, 32'hCAFE);
        expect_v("ar_pre_nb", OBS_NB_RD0, 32'h1010);
        drain();
        #1 rstn = 1'b0;
        expect_v("ar_rd0", OBS_RD0, 32'h0);
        expect_v("ar_nb_rd0", OBS_NB_RD0, 32'h0);
        expect_v("ar_cnt", OBS_CNT, 32'd0);
        drain();
        step();
        rstn = 1'b1;
        idle();
        ra = {5'd5, 5'd10};
        expect_v("ar_no_commit", OBS_RD0, 32'h0);
        expect_v("ar_nb_no_commit", OBS_NB_RD0, 32'h0);
        expect_v("ar_x5_cleared", OBS_RD1, 32'h0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
